lifo_pop_streamer: RTL

- Read-side controller for the team's `lifo` stack. It owns the stack's read port: `lifo_ren`, `lifo_empty` and `lifo_data`.
- On a `start` command it pops a burst of entries, either a fixed count or until the stack is empty.
- Popped words are presented on a valid/ready stream, with a 2-entry skid buffer to absorb downstream stalls.
- Sits between the stack and any consumer that cannot accept data every cycle.

---
 rtl/lifo_pop_streamer.sv | 93 +++++++++
 1 files changed

// File: rtl/lifo_pop_streamer.sv
// lifo_pop_streamer: pops a burst from the lifo stack and streams it out through a 2-entry skid buffer
module lifo_pop_streamer #(
    parameter int DATA_WIDTH = 8,
    parameter int BUFFER_NO  = 8,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  burst_len,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  pop_count,
    output logic                  lifo_ren,
    input  logic                  lifo_empty,
    input  logic [DATA_WIDTH-1:0] lifo_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] POP   = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;
    localparam logic [CNT_WIDTH-1:0] MAX_POP = CNT_WIDTH'(BUFFER_NO);

    logic [1:0]            state;
    logic [CNT_WIDTH-1:0]  remaining;
    logic                  drain;
    logic                  in_flight;
    logic [1:0]            occ;
    logic [1:0]            occ_after;
    logic [DATA_WIDTH-1:0] b0, b1;
    logic                  xfer;
    logic                  drained;

    assign m_valid   = occ != 2'd0;
    assign m_data    = b0;
    assign xfer      = m_valid & m_ready;
    // occupancy once this cycle's transfer has left; lets a pop reuse the slot freed this cycle
    assign occ_after = occ - {1'b0, xfer};
    assign drained   = !in_flight && occ == 2'd0;
    assign busy      = state != IDLE;
    assign done      = state == FLUSH && drained;
    assign lifo_ren  = state == POP && !lifo_empty && (remaining != '0 || drain) &&
                       (occ_after == 2'd0 || (occ_after == 2'd1 && !in_flight));

    // burst control: command capture, pop accounting and exit to flush
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            remaining <= '0;
            drain     <= 1'b0;
            pop_count <= '0;
        end else if (state == IDLE) begin
            if (start) begin
                remaining <= (burst_len > MAX_POP) ? MAX_POP : burst_len;
                drain     <= burst_len == '0;
                pop_count <= '0;
                state     <= POP;
            end
        end else if (state == POP) begin
            if (lifo_ren) begin
                pop_count <= pop_count + CNT_WIDTH'(1);
                if (!drain) remaining <= remaining - CNT_WIDTH'(1);
                if (!drain && remaining == CNT_WIDTH'(1)) state <= FLUSH;
            end else if (lifo_empty) begin
                state <= FLUSH;
            end
        end else if (state == FLUSH) begin
            if (drained) state <= IDLE;
        end else begin
            state <= IDLE;
        end
    end

    // skid buffer: head shifts out on transfer, read data lands behind whatever remains
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_flight <= 1'b0;
            occ       <= 2'd0;
            b0        <= '0;
            b1        <= '0;
        end else begin
            in_flight <= lifo_ren;
            occ       <= occ_after + {1'b0, in_flight};
            if (xfer) b0 <= b1;
            if (in_flight) begin
                if (occ_after == 2'd0) b0 <= lifo_data;
                else b1 <= lifo_data;
            end
        end
    end
endmodule
